// File: rtl/roll_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | roll_scheduler: round-robin roll arbiter with decelerating ticks    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module roll_scheduler #(
  parameter int unsigned BASE_PERIOD = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic [3:0] i_rand,
  output logic [3:0] o_value,
  output logic       o_tick,
  output logic       o_busy,
  output logic       o_owner,
  output logic       o_done,
  output logic [3:0] o_result0,
  output logic [3:0] o_result1
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ROLL = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_step, w_step_nxt;
  logic [1:0]  r_pend, w_pend_nxt;
  logic        r_rr, w_rr_nxt;
  logic        r_owner, w_owner_nxt;
  logic [3:0]  r_value, w_value_nxt;
  logic [3:0]  r_res0, w_res0_nxt;
  logic [3:0]  r_res1, w_res1_nxt;
  logic        r_tick, w_tick_nxt;
  logic        r_done, w_done_nxt;

  logic [31:0] w_interval;
  logic        w_last;
  logic [1:0]  w_eff;
  logic        w_pick;
  logic [3:0]  w_sum;

  // Interval doubles every four steps: BASE, 2x, 4x, 8x.
  assign w_interval = 32'(BASE_PERIOD) << r_step[3:2];
  assign w_last     = (r_cnt == (w_interval - 32'd1));
  assign w_eff      = r_pend | i_req;
  assign w_pick     = (w_eff == 2'b11) ? r_rr : w_eff[1];
  assign w_sum      = r_value + i_rand;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= '0;
      r_pend  <= '0;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_value <= '0;
      r_res0  <= '0;
      r_res1  <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_pend  <= w_pend_nxt;
      r_rr    <= w_rr_nxt;
      r_owner <= w_owner_nxt;
      r_value <= w_value_nxt;
      r_res0  <= w_res0_nxt;
      r_res1  <= w_res1_nxt;
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    w_pend_nxt  = r_pend | i_req;
    w_rr_nxt    = r_rr;
    w_owner_nxt = r_owner;
    w_value_nxt = r_value;
    w_res0_nxt  = r_res0;
    w_res1_nxt  = r_res1;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_eff != 2'b00) begin
          // A same-cycle request from the granted player is consumed here.
          w_owner_nxt = w_pick;
          w_rr_nxt    = ~w_pick;
          w_pend_nxt  = w_eff & ~(2'b01 << w_pick);
          w_step_nxt  = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ROLL;
        end
      end
      S_ROLL: begin
        if (w_last) begin
          w_value_nxt = w_sum;
          w_tick_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_step_nxt  = r_step + 4'd1;
          if (r_step == 4'd15) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
            if (r_owner) w_res1_nxt = w_sum;
            else         w_res0_nxt = w_sum;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_value   = r_value;
  assign o_tick    = r_tick;
  assign o_busy    = (r_state == S_ROLL);
  assign o_owner   = r_owner;
  assign o_done    = r_done;
  assign o_result0 = r_res0;
  assign o_result1 = r_res1;

endmodule
`default_nettype wire

// File: tb/tb_roll_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_roll_scheduler: scoreboard bench against a timeline model        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_roll_scheduler;
  localparam int BP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] rnd = 4'd0;
  logic [3:0] o_value, o_result0, o_result1;
  logic       o_tick, o_busy, o_owner, o_done;

  roll_scheduler #(.BASE_PERIOD(BP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_rand(rnd),
    .o_value(o_value), .o_tick(o_tick), .o_busy(o_busy), .o_owner(o_owner),
    .o_done(o_done), .o_result0(o_result0), .o_result1(o_result1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    logic [3:0] r0;
    logic [3:0] r1;
  } exp_t;
  exp_t sbq[$];

  int n_total = 0;
  int n_pass  = 0;
  int tick_at[16];
  bit rand_en = 1'b0;

  // Reference model: a roll is a timeline of tick instants measured from the grant.
  bit         m_busy;
  int         m_el;
  logic [1:0] m_pend, m_eff;
  logic       m_rr, m_owner, m_p;
  logic [3:0] m_val, m_r0, m_r1;
  bit         m_tick, m_done;

  initial begin
    int acc = 0;
    for (int j = 0; j < 16; j++) begin
      acc += BP * (1 << (j / 4));
      tick_at[j] = acc;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_el = 0; m_pend = 0; m_rr = 0; m_owner = 0;
      m_val = 0; m_r0 = 0; m_r1 = 0; m_tick = 0; m_done = 0;
      sbq.delete();
    end else begin
      m_tick = 0;
      m_done = 0;
      if (m_busy) begin
        m_pend = m_pend | req;
        m_el++;
        for (int j = 0; j < 16; j++) begin
          if (m_el == tick_at[j]) begin
            m_val  = m_val + rnd;
            m_tick = 1;
            if (j == 15) begin
              if (m_owner) m_r1 = m_val;
              else         m_r0 = m_val;
              m_done = 1;
              m_busy = 0;
            end
            sbq.push_back('{m_val, m_r0, m_r1});
          end
        end
      end else begin
        m_eff = m_pend | req;
        if (m_eff != 2'b00) begin
          m_p = (m_eff == 2'b11) ? m_rr : m_eff[1];
          m_owner = m_p;
          m_rr = !m_p;
          m_eff[m_p] = 1'b0;
          m_busy = 1;
          m_el = 0;
        end
        m_pend = m_eff;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("tick", int'(o_tick), int'(m_tick));
      chk("done", int'(o_done), int'(m_done));
      chk("busy", int'(o_busy), int'(m_busy));
      chk("owner", int'(o_owner), int'(m_owner));
      if (o_tick || m_tick) begin
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: got tick, expected none at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("value", int'(o_value), int'(e.val));
          chk("result0", int'(o_result0), int'(e.r0));
          chk("result1", int'(o_result1), int'(e.r1));
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (rand_en) rnd = 4'($urandom);
  endtask

  task automatic pulse(input logic [1:0] r);
    cyc();
    req = r;
    cyc();
    req = 2'b00;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || m_pend != 2'b00 || o_busy) && n < budget) begin
      cyc();
      n++;
    end
    n_total++;
    if (n < budget) n_pass++;
    else $display("FAIL idle_timeout: got %0d cycles, expected under %0d", n, budget);
    repeat (3) cyc();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_value"}, int'(o_value), 0);
    chk({nm, "_tick"}, int'(o_tick), 0);
    chk({nm, "_busy"}, int'(o_busy), 0);
    chk({nm, "_owner"}, int'(o_owner), 0);
    chk({nm, "_done"}, int'(o_done), 0);
    chk({nm, "_res0"}, int'(o_result0), 0);
    chk({nm, "_res1"}, int'(o_result1), 0);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #2 rst_n = 1'b1;
    repeat (5) cyc();

    // Single roll, constant increment 3: 16*3 wraps to 0.
    rnd = 4'd3;
    pulse(2'b01);
    wait_idle(600);
    chk("single_value", int'(o_value), 0);
    chk("single_res0", int'(o_result0), 0);
    chk("single_res1", int'(o_result1), 0);

    rand_en = 1'b1;
    pulse(2'b11);
    wait_idle(1200);
    pulse(2'b11);
    wait_idle(1200);

    // Owner re-requests mid-roll.
    pulse(2'b01);
    repeat (50) cyc();
    pulse(2'b01);
    wait_idle(1200);

    for (int i = 0; i < 3000; i++) begin
      cyc();
      req = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
    req = 2'b00;
    wait_idle(3000);

    // Abort at step 7 with player 1 pending.
    pulse(2'b01);
    pulse(2'b10);
    n = 0;
    while (!(m_busy && m_el == 42) && n < 300) begin
      cyc();
      n++;
    end
    chk("reach_step7", int'(m_busy && m_el == 42), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) cyc();
    chk("abort_idle", int'(o_busy), 0);

    // Carry-over from 0: 16*5 = 80 -> 0, then 16*1 = 16 -> 0.
    rand_en = 1'b0;
    rnd = 4'd5;
    pulse(2'b01);
    wait_idle(600);
    chk("carry1_value", int'(o_value), 0);
    chk("carry1_res0", int'(o_result0), 0);
    rnd = 4'd1;
    pulse(2'b10);
    wait_idle(600);
    chk("carry2_value", int'(o_value), 0);
    chk("carry2_res1", int'(o_result1), 0);

    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/roll_scheduler.md
# roll_scheduler

Sequencing and arbitration controller for the board's shared random-roll display path. Two players request rolls through one-cycle pulses, and the block grants the single roll engine to one player at a time using round-robin. It then steps the displayed 4-bit value on a decelerating tick schedule driven by the free-running random source. At the end of each roll it latches the final value into that player's result register.

## Interface
Parameters:
- BASE_PERIOD, default 5000000: cycles between ticks in the fastest phase. Legal range is 1 ≤ BASE_PERIOD, with 8*BASE_PERIOD < 2^32.

Ports:
- i_clk, input, 1: system clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_req, input, 2: per-player roll request pulses; bit p belongs to player p.
- i_rand, input, 4: free-running random source, sampled at every tick.
- o_value, output, 4: currently displayed roll value.
- o_tick, output, 1: one-cycle pulse in the cycle o_value takes a new value.
- o_busy, output, 1: high while a roll is in progress (state ROLL).
- o_owner, output, 1: player holding the current or most recent grant.
- o_done, output, 1: one-cycle pulse marking roll completion.
- o_result0, output, 4: last completed result of player 0.
- o_result1, output, 4: last completed result of player 1.

## Operation
- **Pending flags:** pend[1:0].
  - Set by i_req[p] in any state.
  - Cleared only when player p is granted.
  - A request while pend[p] is already set is absorbed; there is no counting.
- **Round-robin pointer:** rr, the player preferred on a tie.
  - Reset value is 0.
  - After a grant to player p, rr becomes ~p.
- **State IDLE:**
  - If any pend bit is set, or i_req is set that same cycle, grant one player:
    - if only one player is requesting, that player;
    - if both are requesting, player rr.
  - On grant: owner ← p, pend[p] cleared, step ← 0, cnt ← 0, next state ROLL.
  - No pending request: remain in IDLE.
- **State ROLL:**
  - cnt increments every cycle.
  - When cnt == interval(step)-1:
    - o_value ← (o_value + i_rand) mod 16, with the 4-bit sum wrapping;
    - o_tick pulses;
    - cnt ← 0;
    - step ← step+1.
- **Interval schedule:** interval(step) = BASE_PERIOD << (step >> 2), for steps 0–15.
  - Steps 0–3 last BASE_PERIOD each; steps 4–7 last 2×; steps 8–11 last 4×; steps 12–15 last 8×.
  - Total roll length is 60×BASE_PERIOD cycles.
- **Final tick (step 15):**
  - o_value is updated as on any tick.
  - The owner's result register ← the new o_value, in the same cycle.
  - o_done pulses and the state returns to IDLE.
- **Value carry-over:** o_value is not cleared between rolls; each roll continues from the previous value.
- **Requests during ROLL:**
  - They set pend and never preempt the current roll.
  - This includes a repeat request from the current owner, which queues a re-roll.
- **cnt:** 32-bit counter; it never wraps within a legal BASE_PERIOD.

## Timing
- **Reset values:** all outputs, cnt, step, pend and rr are 0, and the state is IDLE. Asserting i_rst_n low mid-roll aborts the roll immediately and clears the result registers.
- **Grant latency:** a request seen at edge k gives ROLL, o_busy=1 and the new o_owner from cycle k+1. The request may be in the same cycle as IDLE, or already pending.
- **First tick:** BASE_PERIOD cycles after entering ROLL. o_value, o_tick and o_result are all registered outputs.
- **Completion cycle:**
  - o_done=1, o_tick=1, o_busy=0 and the updated result are visible together;
  - the state is IDLE.
- **Back-to-back rolls:** a pending request is granted at the edge ending the completion cycle. The gap between rolls is therefore exactly one non-busy cycle.
- **Simultaneous events:**
  - i_req[p] arriving in the same cycle p is granted is consumed by that grant and does not leave pend[p] set.
  - Both bits requesting in the same cycle: grant to rr, the other stays pending.
- **o_owner:** holds its value through IDLE until the next grant.

## Test plan
All scenarios use BASE_PERIOD=4, giving a 240-cycle roll.
- **Reset:** hold i_rst_n low -> all outputs 0. Release -> state IDLE, no o_tick.
- **Single roll:** i_req=01 pulse, i_rand held at 3.
  - o_busy rises on the next cycle.
  - Ticks occur at +4, 8, 12, 16, 24, … cycles.
  - 16 ticks total, with o_value=0 after the 16th (16×3 mod 16).
  - o_done arrives 240 cycles after ROLL entry, with o_result0=0 and o_result1 unchanged.
- **Tie and round-robin:** i_req=11 right after reset.
  - Player 0 is granted; player 1 is granted one cycle after the first o_done.
  - A further tie after that grants player 0 (rr=0).
- **Queued re-roll:** owner 0 pulses i_req=01 mid-roll -> a second roll for player 0 starts one cycle after o_done.
- **Carry-over and wrap:** i_rand=5, starting o_value=0 -> after roll 1 o_value=0 (80 mod 16). Then i_rand=1 -> after roll 2 o_value=0 (16 mod 16).
- **Reset mid-roll:** assert i_rst_n low at step 7 -> o_busy=0, o_value=0, results=0 and pend cleared. No o_done until a new request.
